// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the ALU instruction sequencer.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_CMP  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_NOT  = 5'd6;
  localparam logic [4:0] ALU_LSH  = 5'd7;
  localparam logic [4:0] ALU_RSH  = 5'd8;
  localparam logic [4:0] ALU_ARSH = 5'd9;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;

  // Register forms select by ext; immediate forms reuse the same code in op.
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  localparam logic [3:0] EXT_NOT  = 4'b0000;
  localparam logic [3:0] EXT_LSH  = 4'b0100;
  localparam logic [3:0] EXT_RSH  = 4'b0110;
  localparam logic [3:0] EXT_ARSH = 4'b0111;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational instruction decoder.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output logic [4:0]  alu_op,
  output logic        imm_sel,
  output logic        sign_ext,
  output logic        rf_write,
  output logic        flags_write,
  output logic        is_cmp,
  output logic        is_mov,
  output logic        illegal
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [3:0] code;
  logic       unused_reg_fields;

  assign op  = instr[15:12];
  assign ext = instr[7:4];
  assign unused_reg_fields = ^{instr[11:8], instr[3:0]};

  always_comb begin
    alu_op      = ALU_ADD;
    imm_sel     = 1'b0;
    sign_ext    = 1'b0;
    rf_write    = 1'b0;
    flags_write = 1'b0;
    is_cmp      = 1'b0;
    is_mov      = 1'b0;
    illegal     = 1'b0;
    code        = ext;
    if (op == OP_SHIFT) begin
      rf_write = 1'b1;
      case (ext)
        EXT_NOT:  alu_op = ALU_NOT;
        EXT_LSH:  alu_op = ALU_LSH;
        EXT_RSH:  alu_op = ALU_RSH;
        EXT_ARSH: alu_op = ALU_ARSH;
        default: begin
          rf_write = 1'b0;
          illegal  = 1'b1;
        end
      endcase
    end else begin
      imm_sel  = (op != OP_RTYPE);
      code     = imm_sel ? op : ext;
      rf_write = 1'b1;
      case (code)
        EXT_AND: alu_op = ALU_AND;
        EXT_OR:  alu_op = ALU_OR;
        EXT_XOR: alu_op = ALU_XOR;
        EXT_ADD: begin
          alu_op      = ALU_ADD;
          flags_write = 1'b1;
          sign_ext    = imm_sel;
        end
        EXT_SUB: begin
          alu_op      = ALU_SUB;
          flags_write = 1'b1;
          sign_ext    = imm_sel;
        end
        EXT_CMP: begin
          alu_op      = ALU_CMP;
          flags_write = 1'b1;
          sign_ext    = imm_sel;
          is_cmp      = 1'b1;
          rf_write    = 1'b0;
        end
        EXT_MOV: is_mov = 1'b1;
        default: begin
          imm_sel  = 1'b0;
          rf_write = 1'b0;
          illegal  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - fetch/decode/exec/writeback sequencer for the 16-bit ALU datapath.
// Define ALU_CTRL_PERF_CNT_EN to add the retired_cnt instruction counter.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              instr_req,
  input  logic              instr_ack,
  input  logic [15:0]       instr_data,
  output logic [REG_AW-1:0] rf_addr_a,
  output logic [REG_AW-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic [DATA_W-1:0] alu_rdest,
  output logic [DATA_W-1:0] alu_rsrc,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        flags,
  output logic              pc_inc,
  output logic              illegal
`ifdef ALU_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  state_t            state;
  logic [15:0]       instr_q;
  logic [4:0]        dec_alu_op;
  logic              dec_imm_sel;
  logic              dec_sign_ext;
  logic              dec_rf_write;
  logic              dec_flags_write;
  logic              dec_is_cmp;
  logic              dec_is_mov;
  logic              dec_illegal;
  logic [DATA_W-1:0] imm_ext;
  logic [4:0]        arith_flags;
  logic [4:0]        cmp_flags;

  alu_ctrl_decode u_decode (
    .instr       (instr_q),
    .alu_op      (dec_alu_op),
    .imm_sel     (dec_imm_sel),
    .sign_ext    (dec_sign_ext),
    .rf_write    (dec_rf_write),
    .flags_write (dec_flags_write),
    .is_cmp      (dec_is_cmp),
    .is_mov      (dec_is_mov),
    .illegal     (dec_illegal)
  );

  // Read addresses come straight from the latched instruction so they are stable for all of DECODE.
  assign rf_addr_a = instr_q[8 +: REG_AW];
  assign rf_addr_b = instr_q[0 +: REG_AW];

  assign imm_ext = dec_sign_ext ? {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]}
                                : {{(DATA_W-8){1'b0}}, instr_q[7:0]};

  always_comb begin
    arith_flags         = alu_flags;
    arith_flags[FLAG_Z] = 1'b0;
    cmp_flags           = '0;
    cmp_flags[FLAG_L]   = alu_flags[FLAG_L];
    cmp_flags[FLAG_N]   = alu_flags[FLAG_N];
    cmp_flags[FLAG_Z]   = (alu_rdest == alu_rsrc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      instr_q   <= '0;
      instr_req <= 1'b0;
      alu_rdest <= '0;
      alu_rsrc  <= '0;
      alu_op    <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      flags     <= '0;
      pc_inc    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      pc_inc  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state     <= FETCH;
            instr_req <= 1'b1;
          end
        end
        FETCH: begin
          if (instr_ack) begin
            instr_q   <= instr_data;
            instr_req <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          alu_rdest <= rf_data_a;
          alu_rsrc  <= dec_imm_sel ? imm_ext : rf_data_b;
          alu_op    <= dec_alu_op;
          state     <= EXEC;
        end
        EXEC: begin
          // Strobes land in WB; MOV bypasses the ALU with the latched source operand.
          rf_we   <= dec_rf_write;
          pc_inc  <= 1'b1;
          illegal <= dec_illegal;
          if (dec_rf_write) begin
            rf_waddr <= instr_q[8 +: REG_AW];
            rf_wdata <= dec_is_mov ? alu_rsrc : alu_out;
          end
          if (dec_flags_write) begin
            flags <= dec_is_cmp ? cmp_flags : arith_flags;
          end
          state <= WB;
        end
        WB: begin
          if (run) begin
            state     <= FETCH;
            instr_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (pc_inc) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb/tb_alu_ctrl_fsm.sv - self-checking bench for alu_ctrl_fsm with a behavioural ISA model.
module tb_alu_ctrl_fsm;

  localparam int M_ADD = 0, M_SUB = 1, M_CMP = 2, M_AND = 3, M_OR = 4, M_XOR = 5;
  localparam int M_NOT = 6, M_LSH = 7, M_RSH = 8, M_ARSH = 9, M_MOV = 10, M_ILL = 11;

  logic        clk;
  logic        reset;
  logic        run;
  logic        instr_req;
  logic        instr_ack;
  logic [15:0] instr_data;
  logic [3:0]  rf_addr_a, rf_addr_b, rf_waddr;
  logic [15:0] rf_data_a, rf_data_b;
  logic [15:0] alu_rdest, alu_rsrc, alu_out, rf_wdata;
  logic [4:0]  alu_op, alu_flags, flags;
  logic        rf_we, pc_inc, illegal;
`ifdef ALU_CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  logic [15:0] regs [16];
  logic [4:0]  model_flags;
  int          exp_retired;
  int          checks;
  int          errors;

  alu_ctrl_fsm #(.DATA_W(16), .REG_AW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr_req  (instr_req),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .rf_addr_a  (rf_addr_a),
    .rf_addr_b  (rf_addr_b),
    .rf_data_a  (rf_data_a),
    .rf_data_b  (rf_data_b),
    .alu_rdest  (alu_rdest),
    .alu_rsrc   (alu_rsrc),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flags      (flags),
    .pc_inc     (pc_inc),
    .illegal    (illegal)
`ifdef ALU_CTRL_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  // Environment ALU: returns {flags, result}; non-arithmetic ops report junk flags on purpose.
  function automatic logic [20:0] tb_alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  f;
    s = '0;
    r = '0;
    f = '0;
    case (op)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        f[0] = s[16];
        f[2] = (a[15] == b[15]) && (r[15] != a[15]);
        f[4] = r[15];
      end
      5'd1, 5'd2: begin
        r = a - b;
        f[0] = (a < b);
        f[1] = (a < b);
        f[2] = (a[15] != b[15]) && (r[15] != a[15]);
        f[4] = (op == 5'd2) ? ($signed(a) < $signed(b)) : r[15];
      end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = a ^ b;
      5'd6: r = ~b;
      5'd7: r = b << 1;
      5'd8: r = b >> 1;
      5'd9: r = {b[15], b[15:1]};
      default: r = 16'hDEAD;
    endcase
    f[3] = (r == 16'h0000);
    if (op >= 5'd3) f = f ^ 5'b10111;
    return {f, r};
  endfunction

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];
  assign {alu_flags, alu_out} = tb_alu(alu_op, alu_rdest, alu_rsrc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Runs one instruction through fetch..writeback, checking each stage against the ISA model.
  task automatic do_instr(input logic [15:0] ins, input int delay, input logic keep_run);
    logic [3:0]  op, ext, rd, rs;
    logic [7:0]  imm8;
    logic        is_imm, exp_we, exp_ill;
    logic [15:0] a, b, exp_wd;
    logic [20:0] af;
    int          mn, n, req_cnt;
    run = 1'b1;
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (instr_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_timeout instr_req=%b required=1", instr_req);
      return;
    end
    op = ins[15:12]; ext = ins[7:4]; rd = ins[11:8]; rs = ins[3:0]; imm8 = ins[7:0];
    is_imm = 1'b0;
    mn = M_ILL;
    if (op == 4'h8) begin
      case (ext)
        4'h0: mn = M_NOT;
        4'h4: mn = M_LSH;
        4'h6: mn = M_RSH;
        4'h7: mn = M_ARSH;
        default: mn = M_ILL;
      endcase
    end else begin
      is_imm = (op != 4'h0);
      case (is_imm ? op : ext)
        4'd1:  mn = M_AND;
        4'd2:  mn = M_OR;
        4'd3:  mn = M_XOR;
        4'd5:  mn = M_ADD;
        4'd9:  mn = M_SUB;
        4'd11: mn = M_CMP;
        4'd13: mn = M_MOV;
        default: mn = M_ILL;
      endcase
    end
    a = regs[rd];
    if (!is_imm) b = regs[rs];
    else if (mn == M_ADD || mn == M_SUB || mn == M_CMP) b = {{8{imm8[7]}}, imm8};
    else b = {8'h00, imm8};
    case (mn)
      M_ADD:  exp_wd = a + b;
      M_SUB:  exp_wd = a - b;
      M_AND:  exp_wd = a & b;
      M_OR:   exp_wd = a | b;
      M_XOR:  exp_wd = a ^ b;
      M_NOT:  exp_wd = ~b;
      M_LSH:  exp_wd = b << 1;
      M_RSH:  exp_wd = b >> 1;
      M_ARSH: exp_wd = 16'($signed(b) >>> 1);
      M_MOV:  exp_wd = b;
      default: exp_wd = 16'h0000;
    endcase
    af = tb_alu(5'(mn), a, b);
    exp_we  = !(mn == M_CMP || mn == M_ILL);
    exp_ill = (mn == M_ILL);
    if (mn == M_ADD || mn == M_SUB) model_flags = {af[20], 1'b0, af[18], af[17], af[16]};
    if (mn == M_CMP) model_flags = {af[20], (a == b), 1'b0, af[17], 1'b0};

    req_cnt = 1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (instr_req === 1'b1) req_cnt++;
    end
    instr_ack  = 1'b1;
    instr_data = ins;
    @(negedge clk);
    instr_ack  = 1'($urandom_range(0, 1));
    instr_data = 16'($urandom);
    run = keep_run;
    checks++;
    if (req_cnt != delay + 1) begin
      errors++;
      $display("FAIL req_high_cycles got=%0d required=%0d", req_cnt, delay + 1);
    end
    checks++;
    if ({instr_req, rf_addr_a, rf_addr_b} !== {1'b0, rd, rs}) begin
      errors++;
      $display("FAIL decode_addr req/a/b got=%b/%h/%h required=0/%h/%h", instr_req, rf_addr_a, rf_addr_b, rd, rs);
    end
    @(negedge clk);
    checks++;
    if ({rf_we, pc_inc, illegal} !== 3'b000) begin
      errors++;
      $display("FAIL exec_no_strobe we/inc/ill got=%b%b%b required=000", rf_we, pc_inc, illegal);
    end
    if (mn != M_ILL) begin
      checks++;
      if ({alu_rdest, alu_rsrc} !== {a, b}) begin
        errors++;
        $display("FAIL exec_operands ins=%h got=%h/%h required=%h/%h", ins, alu_rdest, alu_rsrc, a, b);
      end
    end
    if (mn != M_ILL && mn != M_MOV) begin
      checks++;
      if (alu_op !== 5'(mn)) begin
        errors++;
        $display("FAIL exec_alu_op ins=%h got=%0d required=%0d", ins, alu_op, mn);
      end
    end
    @(negedge clk);
    instr_ack = 1'b0;
    checks++;
    if ({rf_we, pc_inc, illegal, flags} !== {exp_we, 1'b1, exp_ill, model_flags}) begin
      errors++;
      $display("FAIL wb_ctrl ins=%h we/inc/ill/flags got=%b%b%b/%b required=%b1%b/%b",
               ins, rf_we, pc_inc, illegal, flags, exp_we, exp_ill, model_flags);
    end
    if (exp_we) begin
      checks++;
      if ({rf_waddr, rf_wdata} !== {rd, exp_wd}) begin
        errors++;
        $display("FAIL wb_data ins=%h got=%h:%h required=%h:%h", ins, rf_waddr, rf_wdata, rd, exp_wd);
      end
      regs[rd] = exp_wd;
    end
    exp_retired++;
    if (!keep_run) begin
      @(negedge clk);
      checks++;
      if ({instr_req, pc_inc} !== 2'b00) begin
        errors++;
        $display("FAIL idle_after_wb req/inc got=%b%b required=00", instr_req, pc_inc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 1'b1;
    instr_ack = 1'b0;
    instr_data = '0;
    model_flags = '0;
    exp_retired = 0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({instr_req, rf_we, pc_inc, illegal, flags, alu_op, rf_waddr, rf_addr_a, rf_addr_b} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b we=%b inc=%b ill=%b flags=%b op=%h wa=%h a=%h b=%h required=all 0",
               instr_req, rf_we, pc_inc, illegal, flags, alu_op, rf_waddr, rf_addr_a, rf_addr_b);
    end
    checks++;
    if ({alu_rdest, alu_rsrc, rf_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h required 0/0/0", alu_rdest, alu_rsrc, rf_wdata);
    end
    run = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_run instr_req=%b required=0", instr_req);
    end
  endtask

  task automatic test_add();
    regs[1] = 16'h0005;
    regs[2] = 16'h0003;
    do_instr(16'h0152, 1, 1'b1);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, flags, pc_inc} !== {1'b1, 4'd1, 16'h0008, 5'b00000, 1'b1}) begin
      errors++;
      $display("FAIL add_basic we/wa/wd/flags/inc got=%b/%h/%h/%b/%b required=1/1/0008/00000/1",
               rf_we, rf_waddr, rf_wdata, flags, pc_inc);
    end
  endtask

  task automatic test_add_carry();
    regs[1] = 16'hFFFF;
    regs[2] = 16'h0001;
    do_instr(16'h0152, 0, 1'b1);
    checks++;
    if ({rf_wdata, flags[0], flags[3]} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_carry wd/C/Z got=%h/%b/%b required=0000/1/0", rf_wdata, flags[0], flags[3]);
    end
  endtask

  task automatic test_subi();
    regs[1] = 16'h0005;
    do_instr(16'h91FF, 2, 1'b1);
    checks++;
    if ({alu_op, alu_rsrc, rf_wdata} !== {5'd1, 16'hFFFF, 16'h0006}) begin
      errors++;
      $display("FAIL subi op/rsrc/wd got=%0d/%h/%h required=1/FFFF/0006", alu_op, alu_rsrc, rf_wdata);
    end
  endtask

  task automatic test_cmp();
    regs[1] = 16'h0007;
    regs[2] = 16'h0007;
    do_instr(16'h01B2, 0, 1'b1);
    checks++;
    if ({rf_we, flags} !== {1'b0, 5'b01000}) begin
      errors++;
      $display("FAIL cmp_equal we/flags got=%b/%b required=0/01000", rf_we, flags);
    end
    regs[1] = 16'hFFFF;
    regs[2] = 16'h0001;
    do_instr(16'h01B2, 1, 1'b1);
    checks++;
    if ({rf_we, flags} !== {1'b0, 5'b10000}) begin
      errors++;
      $display("FAIL cmp_signed we/flags got=%b/%b required=0/10000", rf_we, flags);
    end
  endtask

  task automatic test_illegal();
    do_instr(16'hF000, 0, 1'b1);
    checks++;
    if ({illegal, pc_inc, rf_we, flags} !== {1'b1, 1'b1, 1'b0, 5'b10000}) begin
      errors++;
      $display("FAIL illegal ill/inc/we/flags got=%b%b%b/%b required=110/10000", illegal, pc_inc, rf_we, flags);
    end
  endtask

  task automatic test_run_park();
    int hi;
    regs[5] = 16'h00F0;
    do_instr(16'h05D5, 0, 1'b0);
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (instr_req !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL run_park req_high_cycles got=%0d required=0", hi);
    end
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_req !== 1'b1) begin
      errors++;
      $display("FAIL run_resume instr_req=%b required=1", instr_req);
    end
    do_instr(16'hD37F, 0, 1'b1);
  endtask

  task automatic test_ack_delay();
    regs[6] = 16'h8001;
    do_instr(16'h8676, 5, 1'b1);
  endtask

  task automatic test_reset_exec();
    int n;
    int bad;
    regs[3] = 16'h1234;
    regs[4] = 16'h0001;
    run = 1'b1;
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (instr_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_exec_req_timeout instr_req=%b required=1", instr_req);
    end
    instr_ack = 1'b1;
    instr_data = 16'h0354;
    @(negedge clk);
    instr_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({instr_req, rf_we, pc_inc, illegal, flags, alu_op, alu_rdest, alu_rsrc, rf_wdata, rf_waddr} !== '0) begin
      errors++;
      $display("FAIL reset_async flags=%b op=%h rd=%h rs=%h wd=%h wa=%h req=%b we=%b inc=%b required=all 0",
               flags, alu_op, alu_rdest, alu_rsrc, rf_wdata, rf_waddr, instr_req, rf_we, pc_inc);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rf_we !== 1'b0 || pc_inc !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_exec_strobes cycles_with_strobe=%0d required=0", bad);
    end
    reset = 1'b0;
    model_flags = '0;
    exp_retired = 0;
  endtask

  task automatic test_random();
    logic [3:0]  rcodes [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    logic [3:0]  scodes [4] = '{4'h0, 4'h4, 4'h6, 4'h7};
    logic [15:0] ins;
    logic [3:0]  rd, rs;
    int          sel;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 9);
      rd = 4'($urandom);
      rs = 4'($urandom);
      if (sel == 0) ins = 16'($urandom);
      else if (sel <= 3) ins = {4'h0, rd, rcodes[$urandom_range(0, 6)], rs};
      else if (sel <= 6) ins = {rcodes[$urandom_range(0, 6)], rd, 8'($urandom)};
      else ins = {4'h8, rd, scodes[$urandom_range(0, 3)], rs};
      do_instr(ins, $urandom_range(0, 3), ($urandom_range(0, 5) != 0));
    end
  endtask

  task automatic test_perf();
`ifdef ALU_CTRL_PERF_CNT_EN
    repeat (2) @(negedge clk);
    checks++;
    if (retired_cnt !== 32'(exp_retired)) begin
      errors++;
      $display("FAIL retired_cnt got=%0d required=%0d", retired_cnt, exp_retired);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_add_carry();
    test_subi();
    test_cmp();
    test_illegal();
    test_run_park();
    test_ack_delay();
    test_reset_exec();
    test_random();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle instruction sequencer for the 16-bit ALU datapath.
- Fetches one 16-bit instruction over a req/ack handshake and decodes register and immediate forms.
- Drives register-file read addresses, ALU operands and the 5-bit ALU opcode, then writes back the result and the architectural flags register (C,L,F,Z,N).
- Sits between instruction memory, register file and ALU; pulses pc_inc once per retired instruction.

Parameters:
- DATA_W, 16, datapath width
- REG_AW, 4, register address width (16 registers)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  permit fetching a new instruction
- instr_req  out  1  instruction fetch request
- instr_ack  in  1  instr_data valid this cycle
- instr_data  in  16  instruction word
- rf_addr_a  out  4  Rdest read address
- rf_addr_b  out  4  Rsrc read address
- rf_data_a  in  16  Rdest read data (combinational)
- rf_data_b  in  16  Rsrc read data (combinational)
- alu_rdest  out  16  ALU Rdest operand
- alu_rsrc  out  16  ALU Rsrc operand (register or extended immediate)
- alu_op  out  5  ALU opcode
- alu_out  in  16  ALU result
- alu_flags  in  5  ALU flags: [0]C [1]L [2]F [3]Z [4]N
- rf_we  out  1  register write strobe
- rf_waddr  out  4  write address
- rf_wdata  out  16  write data
- flags  out  5  architectural flags register
- pc_inc  out  1  one-cycle retire pulse
- illegal  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Reset (async) clears all outputs, flags, the latched instruction and operands to 0; the state machine goes to IDLE.
- States:
  - IDLE: go to FETCH when run=1.
  - FETCH: instr_req=1 until instr_ack. In the ack cycle, latch instr_data and go to DECODE. instr_req drops the cycle after ack.
  - DECODE: drive rf_addr_a=instr[11:8] and rf_addr_b=instr[3:0]. Latch operands at the end of the cycle.
  - EXEC: drive alu_rdest, alu_rsrc and alu_op; latch alu_out and alu_flags.
  - WB: rf_we, pc_inc and the flags update occur here. Go to FETCH if run=1, else IDLE.
- Latency: 4 cycles after ack, with minimum 1 wait cycle in FETCH. rf_we, pc_inc and illegal are single-cycle pulses and are asserted only in WB.
- Encoding: op=instr[15:12], ext=instr[7:4].
  - R-type (op=0000), by ext: AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101.
  - Immediate forms use op = same code as the ext above; imm=instr[7:0].
    - ADDI, SUBI, CMPI: sign-extend imm.
    - ANDI, ORI, XORI, MOVI: zero-extend imm.
  - Shift/unary (op=1000), by ext: NOT 0000, LSH 0100, RSH 0110, ARSH 0111. These take Rsrc as input and write Rdest.
- ALU opcodes: ADD 0, SUB 1, CMP 2, AND 3, OR 4, XOR 5, NOT 6, LSH 7, RSH 8, ARSH 9.
- MOV/MOVI: ALU is bypassed; rf_wdata = Rsrc or immediate; flags are unchanged.
- Writeback:
  - All ops except CMP/CMPI write Rdest.
  - CMP/CMPI write no register.
- Flags:
  - Flags register updates only for ADD, SUB and CMP (register and immediate forms).
  - For ADD/SUB: C, L, F, N are taken from alu_flags; Z is forced 0.
  - For CMP: L and N are taken from alu_flags; Z=(Rdest==Rsrc operand); C=0 and F=0.
  - All other ops hold the flags register.
- Undecodable instruction: WB asserts illegal and pc_inc, with no rf_we and no flags change.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction does not abort it.
- instr_ack outside FETCH is ignored.
- Reset mid-instruction discards it: no write, no pc_inc.

Optional Feature:
- Macro ALU_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output retired_cnt [31:0], which increments on every pc_inc (illegal instructions included).
  - Cleared by reset; wraps 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU opcode constants (ADD..ARSH)
  - op and ext encodings
  - flag bit indices C=0, L=1, F=2, Z=3, N=4
  - state enum IDLE/FETCH/DECODE/EXEC/WB
- One sub-module, alu_ctrl_decode: purely combinational.
  - Input: instruction.
  - Outputs: alu_op, imm_sel, sign_ext, rf_write, flags_write, is_cmp, is_mov, illegal.
- The FSM, latches and flags register live in alu_ctrl_fsm.

Test Plan:
- ADD: R1=0x0005, R2=0x0003, instr 0x0152 -> WB: rf_we=1, rf_waddr=1, rf_wdata=0x0008, flags=00000, pc_inc=1.
- ADD with carry: R1=0xFFFF, R2=0x0001, instr 0x0152 -> rf_wdata=0x0000, flags[0]=1.
- SUBI: R1=0x0005, instr 0x91FF (imm sign-extends to 0xFFFF) -> alu_op=1, alu_rsrc=0xFFFF, rf_wdata=0x0006.
- CMP equal: R1=R2=0x0007, instr 0x01B2 -> no rf_we, flags Z=1, L=0, N=0. Repeat with R1=0xFFFF, R2=0x0001 -> N=1, L=0, Z=0.
- Illegal and run control:
  - instr 0xF000 -> illegal and pc_inc pulse; no rf_we; flags unchanged.
  - run=0 in WB -> FSM parks in IDLE with instr_req=0 until run=1.
- Reset in EXEC and ack delay:
  - Assert reset during EXEC -> no rf_we, no pc_inc; all outputs 0 asynchronously.
  - With instr_ack delayed 5 cycles, instr_req stays high for exactly 6 cycles.
